// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue controller slice.
// Holds opcode encodings, FSM state encodings and instruction field positions.
package alu_pkg;

  // ALU opcodes carried in instr[15:13]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_DIV2 = 3'b100;
  localparam logic [2:0] OP_GT   = 3'b101;
  localparam logic [2:0] OP_LT   = 3'b110;
  localparam logic [2:0] OP_SHL  = 3'b111;

  // Issue FSM states; ST_WB_HI is only reachable when the high-half writeback is built in
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_WB    = 2'b10,
    ST_WB_HI = 2'b11
  } state_t;

  // Instruction field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_LSB  = 10;
  localparam int RS1_LSB = 7;
  localparam int RS2_LSB = 4;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DW register file with two combinational read ports,
// one synchronous write port and asynchronous clear on rst_n.
module alu_regfile #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem_r [NREG];

  // Storage: cleared asynchronously, written on the clock edge when we is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_r[raddr_a];
  assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts 16-bit instructions, reads operands from the local
// register file, drives the external combinational ALU, captures its result
// and flags, and writes the low half of the result back to rd.
// Build option: define MUL_HI_WB_EN to also write the high half of a multiply
// result to rd+1 (mod NREG) through an extra WB_HI cycle.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [15:0]   instr,
  output logic          instr_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [31:0]   alu_d_out,
  input  logic          alu_z,
  input  logic          alu_agb,
  input  logic          alu_bga,
  output logic          res_valid,
  output logic [31:0]   res_data,
  output logic [2:0]    flags
);

  localparam int AW = $clog2(NREG);

  state_t        state_r;
  logic [AW-1:0] rd_r;
  logic [DW-1:0] alu_a_r;
  logic [DW-1:0] alu_b_r;
  logic [2:0]    alu_op_r;
  logic [31:0]   res_data_r;
  logic          res_valid_r;
  logic [2:0]    flags_r;

  logic [2:0]    op_s;
  logic [AW-1:0] rd_s;
  logic [AW-1:0] rs1_s;
  logic [AW-1:0] rs2_s;
  logic [3:0]    unused_instr_s;

  logic [DW-1:0] rdata_a_s;
  logic [DW-1:0] rdata_b_s;
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [DW-1:0] wdata_s;

  // Instruction field decode; operands are read straight from the offered instruction
  assign op_s           = instr[OP_MSB:OP_LSB];
  assign rd_s           = instr[RD_LSB +: AW];
  assign rs1_s          = instr[RS1_LSB +: AW];
  assign rs2_s          = instr[RS2_LSB +: AW];
  assign unused_instr_s = instr[RS2_LSB-1:0];

  alu_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we_s),
    .waddr   (waddr_s),
    .wdata   (wdata_s),
    .raddr_a (rs1_s),
    .raddr_b (rs2_s),
    .rdata_a (rdata_a_s),
    .rdata_b (rdata_b_s)
  );

  // Writeback port: low half of the result in WB, high half (optional) in WB_HI
  always_comb begin
    we_s    = 1'b0;
    waddr_s = rd_r;
    wdata_s = res_data_r[DW-1:0];
    case (state_r)
      ST_WB: begin
        we_s = 1'b1;
      end
`ifdef MUL_HI_WB_EN
      ST_WB_HI: begin
        we_s    = 1'b1;
        waddr_s = rd_r + AW'(1'b1);
        wdata_s = res_data_r[2*DW-1:DW];
      end
`endif
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Issue FSM with registered ALU drive, result, flags and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rd_r        <= {AW{1'b0}};
      alu_a_r     <= {DW{1'b0}};
      alu_b_r     <= {DW{1'b0}};
      alu_op_r    <= 3'b000;
      res_data_r  <= 32'h0000_0000;
      res_valid_r <= 1'b0;
      flags_r     <= 3'b000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          res_valid_r <= 1'b0;
          if (instr_valid) begin
            rd_r     <= rd_s;
            alu_a_r  <= rdata_a_s;
            alu_b_r  <= rdata_b_s;
            alu_op_r <= op_s;
            state_r  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_data_r  <= alu_d_out;
          flags_r     <= {alu_z, alu_agb, alu_bga};
          res_valid_r <= 1'b1;
          state_r     <= ST_WB;
        end
        ST_WB: begin
          res_valid_r <= 1'b0;
`ifdef MUL_HI_WB_EN
          if (alu_op_r == OP_MUL) begin
            state_r <= ST_WB_HI;
          end else begin
            state_r <= ST_IDLE;
          end
`else
          state_r <= ST_IDLE;
`endif
        end
`ifdef MUL_HI_WB_EN
        ST_WB_HI: begin
          res_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
`endif
        default: begin
          res_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready is held low while reset is asserted so every output reads 0 in reset
  assign instr_ready = rst_n & (state_r == ST_IDLE);
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign alu_op      = alu_op_r;
  assign res_valid   = res_valid_r;
  assign res_data    = res_data_r;
  assign flags       = flags_r;

endmodule
